// File: rtl/main_mem_ctrl.sv
// Word-addressed backing memory behind the cache: fixed-latency access, one request
// outstanding, valid/ready on request and response, saturating read/write statistics.
module main_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic                r_wr;
    logic [ADDR_BITS-1:0] r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_resp_valid;
    logic                r_resp_wr;
    logic [DATA_W-1:0]   r_resp_data;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;

    // NOTE: the array is zero at power-up only; rst leaves it alone so contents survive a reset.
    logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: '0};

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_wr;
    logic [ADDR_BITS-1:0] w_idx;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && req_valid;
    assign w_enter_resp  = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_unused_addr = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};

    // With LATENCY=1 the access completes on the accept edge, so use the live request.
    assign w_wr    = w_accept ? req_wr                     : r_wr;
    assign w_idx   = w_accept ? req_addr[ADDR_BITS+1:2]    : r_idx;
    assign w_wdata = w_accept ? req_data                   : r_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid)  w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 0) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_wr         <= 1'b0;
            r_idx        <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_wr    <= 1'b0;
            r_resp_data  <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_wr   <= req_wr;
                r_idx  <= req_addr[ADDR_BITS+1:2];
                r_data <= req_data;
                r_cnt  <= LOAD;
            end else if (r_state == S_WAIT && r_cnt != 0) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_wr    <= w_wr;
                r_resp_data  <= w_wr ? '0 : r_mem[w_idx];
                if (w_wr) begin
                    if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
                end else begin
                    if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end else if (r_state == S_RESP && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // A reset on the completion edge aborts the access, so the commit is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_wr) r_mem[w_idx] <= w_wdata;
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_wr    = r_resp_wr;
    assign resp_data  = r_resp_data;
    assign rd_count   = r_rd_cnt;
    assign wr_count   = r_wr_cnt;

endmodule
